result_bcd_converter: RTL and testbench
=======================================

// Module: result_bcd_converter
// PURPOSE
//  Downstream of the calculator ALU. Takes the signed binary result and converts it to sign + BCD digits for the
//  7-segment display multiplexer, using sequential shift-add-3 (double dabble), one bit per clock.
//  Also flags results too large for the display width.
// PARAMETERS
//  BITS    21  width of signed input value (two's complement)
//  DIGITS  6   BCD digits presented to display; one extra guard digit kept internally for overflow
// PORTS
//  clock     in   1           system clock, all state on posedge
//  reset     in   1           asynchronous, active-high; forces IDLE and clears all outputs
//  start     in   1           convert request; sampled only in IDLE
//  value     in   BITS        signed result from ALU; captured on accepted start
//  busy      out  1           high while shifting (SHIFT state)
//  done      out  1           one-cycle pulse: digits/negative/overflow freshly valid
//  negative  out  1           value was < 0
//  overflow  out  1           |value| > 10^DIGITS-1 (guard digit non-zero)
//  digits    out  4*DIGITS    BCD, digit0 = [3:0] least significant
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, done=0, negative=0, overflow=0, digits=0.
//  States: IDLE -> SHIFT (start=1) ; SHIFT -> SHIFT while count<BITS ; SHIFT -> FINISH after BITS-th shift ;
//   FINISH -> IDLE unconditionally.
//  Accept: start in IDLE at cycle T latches mag = |value| as BITS-bit unsigned (-2^(BITS-1) -> 2^(BITS-1), no wrap),
//   sign = value[BITS-1]; clears BCD scratch (DIGITS+1 digits) and bit counter.
//  SHIFT, each cycle: every scratch digit >=5 gets +3, then {scratch,mag} shifted left 1; counter +1.
//   busy=1 in cycles T+1..T+BITS.
//  FINISH (cycle T+BITS+1): done=1, busy=0; digits <= low DIGITS scratch digits, overflow <= guard digit!=0,
//   negative <= sign && mag!=0. Outputs hold until next accepted start's FINISH (not cleared in between).
//  Latency start->done = BITS+1 cycles (22 default); max throughput one conversion per BITS+2 cycles.
//  start while busy or in FINISH: ignored, no queuing. value changes after accept: no effect.
//  Reset mid-conversion: immediate abort to IDLE, outputs cleared, no done pulse.
//  Overflow: digits still carry the low DIGITS of the true magnitude (display mux decides what to show).
//  Zero input: digits all 0, negative=0 (no "-0").
// CONFIGURATION
//  LEADING_ZERO_BLANK_EN defined: at FINISH, each digit above the most-significant non-zero digit is
//   replaced by BCD_BLANK (4'hF); digit0 is never blanked; blanking is suppressed when overflow=1. No added latency.
//  Not defined: digits are raw BCD including leading zeros.
// STRUCTURE
//  Shared package calc_pkg: state encoding (IDLE/SHIFT/FINISH), BCD_BLANK=4'hF, DISPLAY_DIGITS=6, RESULT_BITS=21.
//  Sub-module bcd_add3: combinational 4-bit digit correction (in>=5 ? in+3 : in), one instance per scratch digit.
//  Counter width $clog2(BITS+1).
// TESTING
//  value=0 -> after 22 cycles done=1, digits=24'h000000, negative=0, overflow=0.
//  value=998001 -> digits=24'h998001, negative=0; value=-998001 -> digits=24'h998001, negative=1.
//  value=-1048576 (min) -> overflow=1, negative=1, digits=24'h048576.
//  start pulsed again at T+5 with new value -> ignored; single done at T+22 with first value's digits.
//  reset asserted at T+10 -> busy/done/digits 0 same cycle; fresh start afterwards converts correctly.
//  LEADING_ZERO_BLANK_EN, value=42 -> digits=24'hFFFF42; value=0 -> 24'hFFFFF0.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared calculator definitions: converter FSM states, display geometry and BCD blank code.
package calc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_FINISH = 2'd2
  } conv_state_e;

  localparam logic [3:0]  BCD_BLANK      = 4'hF;
  localparam int unsigned DISPLAY_DIGITS = 6;
  localparam int unsigned RESULT_BITS    = 21;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: adds 3 to any BCD digit of 5 or more before the shift.
module bcd_add3 (
  input  logic [3:0] din_i,
  output logic [3:0] dout_o
);

  always_comb begin
    dout_o = din_i;
    if (din_i >= 4'd5) dout_o = din_i + 4'd3;
  end

endmodule

// File: rtl/result_bcd_converter.sv
// Sequential signed-binary to sign + BCD converter (one bit per clock, guard digit for overflow).
// Optional build macro: LEADING_ZERO_BLANK_EN blanks leading zero digits with BCD_BLANK.
module result_bcd_converter
  import calc_pkg::*;
#(
  parameter int unsigned BITS   = RESULT_BITS,
  parameter int unsigned DIGITS = DISPLAY_DIGITS
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [BITS-1:0]       value,
  output logic                  busy,
  output logic                  done,
  output logic                  negative,
  output logic                  overflow,
  output logic [4*DIGITS-1:0]   digits
);

  localparam int unsigned SW = 4 * (DIGITS + 1);
  localparam int unsigned CW = $clog2(BITS + 1);

  conv_state_e         state_q;
  logic [BITS-1:0]     mag_q, mag_d;
  logic [SW-1:0]       scratch_q, scratch_d, corr;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                sign_q;
  logic                busy_q, done_q, neg_q, ovf_q;
  logic [4*DIGITS-1:0] digits_q, digits_d;
  logic [4*DIGITS-1:0] raw;
  logic                ovf_d;

  for (genvar g = 0; g < DIGITS + 1; g++) begin : g_add3
    bcd_add3 u_add3 (
      .din_i  (scratch_q[4*g +: 4]),
      .dout_o (corr[4*g +: 4])
    );
  end

  // Next scratch already includes the final shift, so outputs load on the last SHIFT edge.
  always_comb begin
    scratch_d = {corr[SW-2:0], mag_q[BITS-1]};
    mag_d     = {mag_q[BITS-2:0], 1'b0};
    cnt_d     = cnt_q + CW'(1);
    raw       = scratch_d[4*DIGITS-1:0];
    ovf_d     = |scratch_d[SW-1 -: 4];
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic lead;
  always_comb begin
    digits_d = raw;
    lead     = !ovf_d;
    for (int unsigned k = 0; k < DIGITS - 1; k++) begin
      if (lead && raw[4*(DIGITS-1-k) +: 4] == 4'd0) digits_d[4*(DIGITS-1-k) +: 4] = BCD_BLANK;
      else lead = 1'b0;
    end
  end
`else
  always_comb begin
    digits_d = raw;
  end
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      mag_q     <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      sign_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      neg_q     <= 1'b0;
      ovf_q     <= 1'b0;
      digits_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            // Unsigned magnitude: the most negative input maps to 2^(BITS-1) without wrapping.
            mag_q     <= value[BITS-1] ? (~value + BITS'(1)) : value;
            sign_q    <= value[BITS-1];
            scratch_q <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            state_q   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          scratch_q <= scratch_d;
          mag_q     <= mag_d;
          cnt_q     <= cnt_d;
          if (cnt_q == CW'(BITS - 1)) begin
            state_q  <= ST_FINISH;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            digits_q <= digits_d;
            ovf_q    <= ovf_d;
            // A negative two's-complement value always has a non-zero magnitude.
            neg_q    <= sign_q;
          end
        end
        ST_FINISH: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign negative = neg_q;
  assign overflow = ovf_q;
  assign digits   = digits_q;

endmodule

// File: tb/tb_result_bcd_converter.sv
// Directed + random bench for result_bcd_converter against a decimal-arithmetic reference model.
module tb_result_bcd_converter;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [20:0] value;
  logic        busy, done, negative, overflow;
  logic [23:0] digits;

  int vectors    = 0;
  int miscompares = 0;

  result_bcd_converter #(.BITS(21), .DIGITS(6)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .value    (value),
    .busy     (busy),
    .done     (done),
    .negative (negative),
    .overflow (overflow),
    .digits   (digits)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int abs_of(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic logic [23:0] ref_digits(input int v);
    int          a;
    logic [23:0] d;
    a = abs_of(v);
    for (int k = 0; k < 6; k++) begin
      d[4*k +: 4] = 4'(a % 10);
      a = a / 10;
    end
`ifdef LEADING_ZERO_BLANK_EN
    if (abs_of(v) <= 999999) begin
      for (int k = 5; k >= 1; k--) begin
        if (d[4*k +: 4] != 4'd0) break;
        d[4*k +: 4] = 4'hF;
      end
    end
`endif
    return d;
  endfunction

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      cycle();
      n++;
    end
  endtask

  task automatic convert(input int v);
    int n;
    logic [23:0] exp_d;
    exp_d = ref_digits(v);
    value = v[20:0];
    start = 1'b1;
    cycle();
    start = 1'b0;
    value = 21'($urandom);
    chk("busy_after_accept", 32'(busy), 32'd1);
    wait_done(n);
    chk("latency", 32'(n), 32'd21);
    chk("digits", 32'(digits), 32'(exp_d));
    chk("negative", 32'(negative), 32'(v < 0));
    chk("overflow", 32'(overflow), 32'(abs_of(v) > 999999));
    chk("busy_at_done", 32'(busy), 32'd0);
    cycle();
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("digits_hold", 32'(digits), 32'(exp_d));
  endtask

  initial begin
    int n, pulses, v;
    int dir[10] = '{0, 998001, -998001, -1048576, 999999, 1000000, -1, 1048575, 42, 7};

    reset = 1'b1;
    start = 1'b0;
    value = '0;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_neg", 32'(negative), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_digits", 32'(digits), 32'd0);
    reset = 1'b0;
    cycle();

    for (int i = 0; i < 10; i++) convert(dir[i]);

    for (int i = 0; i < 25; i++) begin
      if (i % 3 == 0) v = int'($urandom_range(0, 2000)) - 1000;
      else            v = int'($urandom_range(0, 2097151)) - 1048576;
      convert(v);
    end

    // start re-pulsed mid-conversion and during FINISH must be ignored
    value = 21'(123456);
    start = 1'b1;
    cycle();
    start = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
    value = 21'(-654321);
    start = 1'b1;
    cycle();
    start = 1'b0;
    wait_done(n);
    chk("ign_latency", 32'(n + 5), 32'd21);
    chk("ign_digits", 32'(digits), 32'(ref_digits(123456)));
    chk("ign_neg", 32'(negative), 32'd0);
    value = 21'(5);
    start = 1'b1;
    cycle();
    start = 1'b0;
    chk("finish_start_ignored", 32'(busy), 32'd0);
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      cycle();
      if (done === 1'b1) pulses++;
    end
    chk("no_extra_done", 32'(pulses), 32'd0);

    // reset mid-conversion after a result with non-zero outputs
    convert(-1048576);
    value = 21'(777);
    start = 1'b1;
    cycle();
    start = 1'b0;
    for (int i = 0; i < 9; i++) cycle();
    reset = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_digits", 32'(digits), 32'd0);
    chk("abort_neg", 32'(negative), 32'd0);
    chk("abort_ovf", 32'(overflow), 32'd0);
    cycle();
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      cycle();
      if (done === 1'b1) pulses++;
    end
    chk("abort_no_done", 32'(pulses), 32'd0);
    convert(-31415);
    convert(0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
